// File: rtl/id_ex_reg.sv
// ID/EX pipeline register: decode-stage bundle captured for execute.
// Optional FORWARDING_EN adds source register numbers for the forwarding unit.
module id_ex_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        flush,
  input  logic [31:0] pc_in,
  input  logic        wb_en_in,
  input  logic        mem_r_en_in,
  input  logic        mem_w_en_in,
  input  logic [3:0]  exe_cmd_in,
  input  logic        b_in,
  input  logic        s_in,
  input  logic [31:0] val_rn_in,
  input  logic [31:0] val_rm_in,
  input  logic        imm_in,
  input  logic [11:0] shift_operand_in,
  input  logic [23:0] signed_imm_24_in,
  input  logic [3:0]  dest_in,
  input  logic [3:0]  sr_in,
`ifdef FORWARDING_EN
  input  logic [3:0]  src1_in,
  input  logic [3:0]  src2_in,
  output logic [3:0]  src1_out,
  output logic [3:0]  src2_out,
`endif
  output logic [31:0] pc_out,
  output logic        wb_en_out,
  output logic        mem_r_en_out,
  output logic        mem_w_en_out,
  output logic [3:0]  exe_cmd_out,
  output logic        b_out,
  output logic        s_out,
  output logic [31:0] val_rn_out,
  output logic [31:0] val_rm_out,
  output logic        imm_out,
  output logic [11:0] shift_operand_out,
  output logic [23:0] signed_imm_24_out,
  output logic [3:0]  dest_out,
  output logic [3:0]  sr_out,
  output logic        is_mem_out,
  output logic        valid_out
);

  typedef struct packed {
`ifdef FORWARDING_EN
    logic [3:0]  src1;
    logic [3:0]  src2;
`endif
    logic [31:0] pc;
    logic        wb_en;
    logic        mem_r_en;
    logic        mem_w_en;
    logic [3:0]  exe_cmd;
    logic        b;
    logic        s;
    logic [31:0] val_rn;
    logic [31:0] val_rm;
    logic        imm;
    logic [11:0] shift_operand;
    logic [23:0] signed_imm_24;
    logic [3:0]  dest;
    logic [3:0]  sr;
    logic        is_mem;
    logic        valid;
  } id_ex_t;

  id_ex_t d;
  id_ex_t q;

  always_comb begin
    d               = '0;
`ifdef FORWARDING_EN
    d.src1          = src1_in;
    d.src2          = src2_in;
`endif
    d.pc            = pc_in;
    d.wb_en         = wb_en_in;
    d.mem_r_en      = mem_r_en_in;
    d.mem_w_en      = mem_w_en_in;
    d.exe_cmd       = exe_cmd_in;
    d.b             = b_in;
    d.s             = s_in;
    d.val_rn        = val_rn_in;
    d.val_rm        = val_rm_in;
    d.imm           = imm_in;
    d.shift_operand = shift_operand_in;
    d.signed_imm_24 = signed_imm_24_in;
    d.dest          = dest_in;
    d.sr            = sr_in;
    d.is_mem        = mem_r_en_in | mem_w_en_in;
    d.valid         = 1'b1;
  end

  // flush beats freeze so a killed slot never lingers as a stall
  always_ff @(posedge clk) begin
    if (rst)
      q <= '0;
    else if (flush)
      q <= '0;
    else if (!freeze)
      q <= d;
  end

`ifdef FORWARDING_EN
  assign src1_out          = q.src1;
  assign src2_out          = q.src2;
`endif
  assign pc_out            = q.pc;
  assign wb_en_out         = q.wb_en;
  assign mem_r_en_out      = q.mem_r_en;
  assign mem_w_en_out      = q.mem_w_en;
  assign exe_cmd_out       = q.exe_cmd;
  assign b_out             = q.b;
  assign s_out             = q.s;
  assign val_rn_out        = q.val_rn;
  assign val_rm_out        = q.val_rm;
  assign imm_out           = q.imm;
  assign shift_operand_out = q.shift_operand;
  assign signed_imm_24_out = q.signed_imm_24;
  assign dest_out          = q.dest;
  assign sr_out            = q.sr;
  assign is_mem_out        = q.is_mem;
  assign valid_out         = q.valid;

endmodule

// File: tb/tb_id_ex_reg.sv
// Directed bench for id_ex_reg: reset, load, freeze, flush priority, resume.
// Source-register checks are included when FORWARDING_EN is defined.
module tb_id_ex_reg;

  logic        clk = 1'b0;
  logic        rst, freeze, flush;
  logic [31:0] pc_in, val_rn_in, val_rm_in;
  logic        wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, imm_in;
  logic [3:0]  exe_cmd_in, dest_in, sr_in;
  logic [11:0] shift_operand_in;
  logic [23:0] signed_imm_24_in;
  logic [31:0] pc_out, val_rn_out, val_rm_out;
  logic        wb_en_out, mem_r_en_out, mem_w_en_out, b_out, s_out, imm_out;
  logic [3:0]  exe_cmd_out, dest_out, sr_out;
  logic [11:0] shift_operand_out;
  logic [23:0] signed_imm_24_out;
  logic        is_mem_out, valid_out;
`ifdef FORWARDING_EN
  logic [3:0]  src1_in, src2_in, src1_out, src2_out;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  id_ex_reg dut (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
    .pc_in(pc_in), .wb_en_in(wb_en_in),
    .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
    .exe_cmd_in(exe_cmd_in), .b_in(b_in), .s_in(s_in),
    .val_rn_in(val_rn_in), .val_rm_in(val_rm_in), .imm_in(imm_in),
    .shift_operand_in(shift_operand_in),
    .signed_imm_24_in(signed_imm_24_in),
    .dest_in(dest_in), .sr_in(sr_in),
`ifdef FORWARDING_EN
    .src1_in(src1_in), .src2_in(src2_in),
    .src1_out(src1_out), .src2_out(src2_out),
`endif
    .pc_out(pc_out), .wb_en_out(wb_en_out),
    .mem_r_en_out(mem_r_en_out), .mem_w_en_out(mem_w_en_out),
    .exe_cmd_out(exe_cmd_out), .b_out(b_out), .s_out(s_out),
    .val_rn_out(val_rn_out), .val_rm_out(val_rm_out),
    .imm_out(imm_out), .shift_operand_out(shift_operand_out),
    .signed_imm_24_out(signed_imm_24_out),
    .dest_out(dest_out), .sr_out(sr_out),
    .is_mem_out(is_mem_out), .valid_out(valid_out)
  );

  logic [151:0] all_out;
  assign all_out = {pc_out, wb_en_out, mem_r_en_out, mem_w_en_out,
                    exe_cmd_out, b_out, s_out, val_rn_out, val_rm_out,
                    imm_out, shift_operand_out, signed_imm_24_out,
                    dest_out, sr_out, is_mem_out, valid_out};

  task automatic chk(input string tag, input logic [159:0] obs,
                     input logic [159:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input logic [31:0] v);
    pc_in = v; val_rn_in = v; val_rm_in = v;
    wb_en_in = v[0]; mem_r_en_in = v[1]; mem_w_en_in = v[2];
    b_in = v[3]; s_in = v[4]; imm_in = v[5];
    exe_cmd_in = v[3:0]; dest_in = v[7:4]; sr_in = v[11:8];
    shift_operand_in = v[11:0]; signed_imm_24_in = v[23:0];
`ifdef FORWARDING_EN
    src1_in = v[3:0]; src2_in = v[7:4];
`endif
  endtask

  initial begin
    rst = 1'b1; freeze = 1'b1; flush = 1'b1;
    fill(32'hFFFF_FFFF);
    step();
    chk("reset_all_out", all_out, '0);
    chk("reset_valid", valid_out, 0);
    chk("reset_is_mem", is_mem_out, 0);

    rst = 1'b0; freeze = 1'b0; flush = 1'b0;
    fill(32'h0);
    pc_in = 32'h0000_0010; val_rm_in = 32'h0000_00FF;
    imm_in = 1'b0; shift_operand_in = 12'h084; mem_r_en_in = 1'b1;
`ifdef FORWARDING_EN
    src1_in = 4'h3; src2_in = 4'hA;
`endif
    step();
    chk("load_pc", pc_out, 32'h10);
    chk("load_rm", val_rm_out, 32'hFF);
    chk("load_shift", shift_operand_out, 12'h084);
    chk("load_imm", imm_out, 0);
    chk("load_mem_r", mem_r_en_out, 1);
    chk("load_is_mem", is_mem_out, 1);
    chk("load_valid", valid_out, 1);
    chk("load_wb", wb_en_out, 0);
`ifdef FORWARDING_EN
    chk("load_src1", src1_out, 4'h3);
    chk("load_src2", src2_out, 4'hA);
`endif

    freeze = 1'b1;
    fill(32'hDEAD_BEEF);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("frz_pc", pc_out, 32'h10);
      chk("frz_rm", val_rm_out, 32'hFF);
      chk("frz_rn", val_rn_out, 32'h0);
      chk("frz_shift", shift_operand_out, 12'h084);
      chk("frz_is_mem", is_mem_out, 1);
      chk("frz_valid", valid_out, 1);
`ifdef FORWARDING_EN
      chk("frz_src1", src1_out, 4'h3);
`endif
    end

    flush = 1'b1; wb_en_in = 1'b1;
    step();
    chk("flfz_wb", wb_en_out, 0);
    chk("flfz_all", all_out, '0);
    chk("flfz_valid", valid_out, 0);
`ifdef FORWARDING_EN
    chk("flush_src1", src1_out, 4'h0);
    chk("flush_src2", src2_out, 4'h0);
`endif

    freeze = 1'b0;
    step();
    chk("flush2_all", all_out, '0);

    flush = 1'b0;
    fill(32'h0);
    pc_in = 32'h0000_0044; val_rn_in = 32'h1234_5678;
    val_rm_in = 32'h8000_0001; wb_en_in = 1'b1; mem_w_en_in = 1'b1;
    exe_cmd_in = 4'hC; b_in = 1'b1; s_in = 1'b1; imm_in = 1'b1;
    shift_operand_in = 12'hFFF; signed_imm_24_in = 24'hABCDEF;
    dest_in = 4'h7; sr_in = 4'h9;
    step();
    chk("res_all", all_out,
        {32'h44, 1'b1, 1'b0, 1'b1, 4'hC, 1'b1, 1'b1,
         32'h1234_5678, 32'h8000_0001, 1'b1, 12'hFFF,
         24'hABCDEF, 4'h7, 4'h9, 1'b1, 1'b1});
    chk("res_simm", signed_imm_24_out, 24'hABCDEF);
    chk("res_is_mem_w", is_mem_out, 1);

    rst = 1'b1; freeze = 1'b1;
    step();
    chk("rst_frz_all", all_out, '0);

    rst = 1'b0;
    step();
    chk("post_rst_frz", all_out, '0);

    freeze = 1'b0; mem_w_en_in = 1'b0;
    step();
    chk("nomem_is_mem", is_mem_out, 0);
    chk("nomem_valid", valid_out, 1);
    chk("nomem_pc", pc_out, 32'h44);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/id_ex_reg.md
ID_EX_REG -- requirements
Module: id_ex_reg

Interface
REQ-001 The block SHALL have port clk, input, 1, the single rising-edge clock.
REQ-002 The block SHALL have port rst, input, 1, synchronous, active-high reset.
REQ-003 The block SHALL have port freeze, input, 1, hazard stall: hold all outputs.
REQ-004 The block SHALL have port flush, input, 1, taken-branch kill: insert bubble.
REQ-005 The block SHALL have ports pc_in/pc_out, in/out, 32, PC+4 of the instruction.
REQ-006 The block SHALL have ports wb_en_in/wb_en_out, in/out, 1, register write-back enable.
REQ-007 The block SHALL have ports mem_r_en_in/mem_r_en_out, in/out, 1, load enable.
REQ-008 The block SHALL have ports mem_w_en_in/mem_w_en_out, in/out, 1, store enable.
REQ-009 The block SHALL have ports exe_cmd_in/exe_cmd_out, in/out, 4, ALU command.
REQ-010 The block SHALL have ports b_in/b_out and s_in/s_out, in/out, 1 each, branch and set-flags.
REQ-011 The block SHALL have ports val_rn_in/val_rn_out and val_rm_in/val_rm_out, in/out, 32 each, operand values.
REQ-012 The block SHALL have ports imm_in/imm_out, in/out, 1, immediate-operand select.
REQ-013 The block SHALL have ports shift_operand_in/shift_operand_out, in/out, 12, shifter/offset field.
REQ-014 The block SHALL have ports signed_imm_24_in/signed_imm_24_out, in/out, 24, branch offset.
REQ-015 The block SHALL have ports dest_in/dest_out, in/out, 4, destination register.
REQ-016 The block SHALL have ports sr_in/sr_out, in/out, 4, status flags {N,Z,C,V} at issue.
REQ-017 The block SHALL have port is_mem_out, output, 1, registered mem_r_en_in OR mem_w_en_in.
REQ-018 The block SHALL have port valid_out, output, 1, stage holds a live instruction.

Function
REQ-019 All _out ports SHALL be registered; load latency exactly one clk edge.
REQ-020 Edge priority SHALL be: rst > flush > freeze > load.
REQ-021 Load (no rst/flush/freeze): every _out SHALL take its _in value; valid_out=1; is_mem_out=mem_r_en_in|mem_w_en_in.
REQ-022 Freeze (flush=0): every output, including valid_out, SHALL hold its previous value.
REQ-023 Flush: every output SHALL become 0 (bubble), regardless of freeze.
REQ-024 A bubble SHALL have wb_en_out=mem_r_en_out=mem_w_en_out=b_out=s_out=is_mem_out=valid_out=0.
REQ-025 Flush asserted on consecutive edges SHALL produce consecutive bubbles; load resumes on first edge with flush=freeze=0.
REQ-026 No field SHALL be modified, sign-extended, or shifted in this block; widths pass unchanged.
REQ-027 Outputs SHALL not depend combinationally on any input.

Reset
REQ-028 On a clk edge with rst=1, every output SHALL be 0, including valid_out and is_mem_out.
REQ-029 rst asserted mid-freeze or mid-flush SHALL override; first edge after rst deasserts SHALL follow REQ-020.

Configuration
REQ-030 Macro FORWARDING_EN, when defined, SHALL add ports src1_in/src1_out and src2_in/src2_out, in/out, 4 each, source register numbers for the forwarding unit, obeying REQ-020..REQ-029.
REQ-031 Without FORWARDING_EN those ports SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-032 rst=1 one edge with all inputs 1s -> all outputs 0, valid_out=0.
REQ-033 Load pc_in=0x00000010, val_rm_in=0x000000FF, imm_in=0, shift_operand_in=0x084, mem_r_en_in=1 -> next edge same values out, is_mem_out=1, valid_out=1.
REQ-034 After REQ-033 load, freeze=1 three edges while inputs change to 0xDEADBEEF -> outputs unchanged all three edges.
REQ-035 freeze=1 and flush=1 same edge with wb_en_in=1 -> wb_en_out=0, all outputs 0, valid_out=0.
REQ-036 FORWARDING_EN defined: src1_in=4'h3, src2_in=4'hA load -> src1_out=3, src2_out=A; then flush -> both 0.
